// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings,
// FSM state enum and byte-enable base masks.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        WAIT0,
        ACC1,
        WAIT1,
        RESP
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [3:0] be_base(mem_size_e sz);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = BE_BYTE;
            SZ_HALF: m = BE_HALF;
            SZ_WORD: m = BE_WORD;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshake bundles of the load/store unit.
// lsu_req_if: core (master) <-> LSU (slave) request/response.
// lsu_mem_if: LSU (master) <-> data memory (slave) word port.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size,
        output req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_signed, req_addr, req_wdata,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr,
        output mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr,
        input  mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts {hi, lo} right by the byte offset,
// keeps 8/16/32 bits per size and sign- or zero-extends.
// Ports: hi, lo (memory words), off, size, sgn -> data.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  mem_size_e   size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [63:0] sh;
    logic        unused_top;

    assign sh = {hi, lo} >> {off, 3'b000};

    // No access ever needs the bytes shifted above bit 31.
    assign unused_top = ^sh[63:32];

    always_comb begin
        data = sh[31:0];
        case (size)
            SZ_BYTE: data = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: data = {{16{sgn & sh[15]}}, sh[15:0]};
            default: data = sh[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time onto a word-aligned
// memory port with byte enables and a valid/ready/rvalid handshake.
// Ports: clk, rst (sync, active-high), req (lsu_req_if.slave),
// mem (lsu_mem_if.master). Parameter TIMEOUT_CYCLES bounds rvalid wait.
// Macro LSU_MISALIGN_SPLIT_EN: word-crossing accesses are split in
// two; when undefined, any misaligned access returns an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic        clk,
    input logic        rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    mem_size_e   size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        split_q, split_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    mem_size_e   rq_size;
    logic [1:0]  rq_off;
    logic        rq_split;
    logic        rq_bad;

    assign rq_size = mem_size_e'(req.req_size);
    assign rq_off  = req.req_addr[1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
    logic rq_cross;
    assign rq_cross = (rq_size == SZ_HALF && rq_off == 2'd3)
                   || (rq_size == SZ_WORD && rq_off != 2'd0);
    assign rq_split = rq_cross;
    assign rq_bad   = (rq_size == SZ_ILLEGAL);
`else
    logic rq_misal;
    assign rq_misal = (rq_size == SZ_HALF && rq_off[0])
                   || (rq_size == SZ_WORD && rq_off != 2'd0);
    assign rq_split = 1'b0;
    assign rq_bad   = (rq_size == SZ_ILLEGAL) || rq_misal;
`endif

    // Lane placement spans two words; upper half feeds access 1.
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] base_addr;
    logic [31:0] ld_data;

    assign be8       = {4'b0000, be_base(size_q)} << addr_q[1:0];
    assign wd64      = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign base_addr = {addr_q[31:2], 2'b00};

    lsu_load_align u_align (
        .hi   (hi_q),
        .lo   (lo_q),
        .off  (addr_q[1:0]),
        .size (size_q),
        .sgn  (sgn_q),
        .data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            split_q <= split_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        split_d = split_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    we_d    = req.req_we;
                    size_d  = rq_size;
                    sgn_d   = req.req_signed;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    split_d = rq_split;
                    err_d   = rq_bad;
                    lo_d    = '0;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = rq_bad ? RESP : ACC0;
                end
            end
            ACC0: begin
                if (mem.mem_ready) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (mem.mem_rvalid) begin
                    lo_d    = mem.mem_rdata;
                    state_d = split_q ? ACC1 : RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACC1: begin
                if (mem.mem_ready) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (mem.mem_rvalid) begin
                    hi_d    = mem.mem_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_valid_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        mem_valid_o  = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            ACC0: begin
                mem_valid_o = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = base_addr;
                mem_be_o    = be8[3:0];
                mem_wdata_o = wd64[31:0];
            end
            ACC1: begin
                mem_valid_o = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = base_addr + 32'd4;
                mem_be_o    = be8[7:4];
                mem_wdata_o = wd64[63:32];
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                // Stores and failed accesses return zero data.
                if (!err_q && !we_q) begin
                    resp_rdata_o = ld_data;
                end
            end
            default: ;
        endcase
    end

    assign req.req_ready  = req_ready_o;
    assign req.resp_valid = resp_valid_o;
    assign req.resp_rdata = resp_rdata_o;
    assign req.resp_err   = resp_err_o;
    assign mem.mem_valid  = mem_valid_o;
    assign mem.mem_we     = mem_we_o;
    assign mem.mem_addr   = mem_addr_o;
    assign mem.mem_be     = mem_be_o;
    assign mem.mem_wdata  = mem_wdata_o;

endmodule
